// File: rtl/sdram_cmd_checker.sv
// Protocol checker for the sdr_ctrl SDRAM command bus: init-sequence FSM, tRP/tRFC spacing,
// refresh interval (only when SDR_CMD_CHK_REF_EN is defined), sticky error flags and a saturating count.
module sdram_cmd_checker #(
    parameter int INIT_NOP_CYC = 10000,
    parameter int INIT_AR_CNT  = 2,
    parameter int TRP_CYC      = 3,
    parameter int TRFC_CYC     = 7,
    parameter int REF_MAX_CYC  = 1560
) (
    input  logic        sdram_clk,
    input  logic        sdram_resetn,
    input  logic        sdr_cs_n,
    input  logic        sdr_ras_n,
    input  logic        sdr_cas_n,
    input  logic        sdr_we_n,
    input  logic        sdr_init_done,
    input  logic        clr_i,
    output logic [3:0]  cmd_o,
    output logic        init_ok_o,
    output logic [4:0]  err_o,
    output logic [15:0] err_cnt_o
);
    localparam logic [3:0] CMD_DESEL = 4'd0, CMD_NOP = 4'd1, CMD_ACT = 4'd2, CMD_RD  = 4'd3,
                           CMD_WR    = 4'd4, CMD_BST = 4'd5, CMD_PRE = 4'd6, CMD_AREF = 4'd7,
                           CMD_MRS   = 4'd8;

    localparam logic [2:0] ST_INIT_WAIT = 3'd0, ST_INIT_PRE = 3'd1, ST_INIT_AR = 3'd2,
                           ST_INIT_MRS  = 3'd3, ST_RUN      = 3'd4;

    localparam int IW = $clog2(INIT_NOP_CYC) + 1;
    localparam int AW = $clog2(INIT_AR_CNT) + 1;
    localparam int PW = $clog2(TRP_CYC) + 1;
    localparam int FW = $clog2(TRFC_CYC) + 1;

    logic [3:0]    cmd_d, cmd_q;
    logic          done_q, done_prev_q;
    logic [2:0]    state_d, state_q;
    logic [IW-1:0] init_cnt_d, init_cnt_q;
    logic [AW-1:0] ar_cnt_d, ar_cnt_q;
    logic [PW-1:0] trp_cnt_d, trp_cnt_q;
    logic [FW-1:0] trfc_cnt_d, trfc_cnt_q;
    logic          init_ok_d, init_ok_q;
    logic [4:0]    err_d, err_q;
    logic [15:0]   err_cnt_d, err_cnt_q;
    logic [4:0]    viol;
    logic          is_idle;

    always_comb begin
        cmd_d = CMD_DESEL;
        if (!sdr_cs_n) begin
            case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
                3'b111:  cmd_d = CMD_NOP;
                3'b011:  cmd_d = CMD_ACT;
                3'b101:  cmd_d = CMD_RD;
                3'b100:  cmd_d = CMD_WR;
                3'b110:  cmd_d = CMD_BST;
                3'b010:  cmd_d = CMD_PRE;
                3'b001:  cmd_d = CMD_AREF;
                default: cmd_d = CMD_MRS;
            endcase
        end
    end

    assign is_idle = (cmd_q == CMD_DESEL) || (cmd_q == CMD_NOP);

    // Init sequence; any unexpected non-idle command raises INIT_SEQ without moving the FSM.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ar_cnt_d   = ar_cnt_q;
        init_ok_d  = init_ok_q;
        viol[0]    = 1'b0;
        case (state_q)
            ST_INIT_WAIT: begin
                if (is_idle) begin
                    if (init_cnt_q != IW'(INIT_NOP_CYC)) init_cnt_d = init_cnt_q + 1'b1;
                    if (init_cnt_q == IW'(INIT_NOP_CYC - 1)) state_d = ST_INIT_PRE;
                end else begin
                    viol[0] = 1'b1;
                end
            end
            ST_INIT_PRE: begin
                if (cmd_q == CMD_PRE) state_d = ST_INIT_AR;
                else if (!is_idle) viol[0] = 1'b1;
            end
            ST_INIT_AR: begin
                if (cmd_q == CMD_AREF) begin
                    ar_cnt_d = ar_cnt_q + 1'b1;
                    if (ar_cnt_q == AW'(INIT_AR_CNT - 1)) state_d = ST_INIT_MRS;
                end else if (!is_idle) begin
                    viol[0] = 1'b1;
                end
            end
            ST_INIT_MRS: begin
                if (cmd_q == CMD_MRS) begin
                    state_d   = ST_RUN;
                    init_ok_d = 1'b1;
                end else if (!is_idle) begin
                    viol[0] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Spacing windows count down from the issuing command; a new PRE/AREF reloads its own window.
    always_comb begin
        trp_cnt_d  = trp_cnt_q;
        trfc_cnt_d = trfc_cnt_q;
        if (cmd_q == CMD_PRE) trp_cnt_d = PW'(TRP_CYC - 1);
        else if (trp_cnt_q != '0) trp_cnt_d = trp_cnt_q - 1'b1;
        if (cmd_q == CMD_AREF) trfc_cnt_d = FW'(TRFC_CYC - 1);
        else if (trfc_cnt_q != '0) trfc_cnt_d = trfc_cnt_q - 1'b1;
        viol[1] = !is_idle && (trp_cnt_q != '0);
        viol[2] = !is_idle && (trfc_cnt_q != '0);
        viol[4] = (done_q && (state_q != ST_RUN)) ||
                  ((state_q == ST_RUN) && !done_q && done_prev_q);
    end

`ifdef SDR_CMD_CHK_REF_EN
    localparam int RW = $clog2(REF_MAX_CYC) + 1;
    logic [RW-1:0] ref_cnt_d, ref_cnt_q;

    // Counter parks at REF_MAX_CYC so the REF flag fires only on the cycle it gets there.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        viol[3]   = 1'b0;
        if (state_q == ST_RUN) begin
            if (cmd_q == CMD_AREF) begin
                ref_cnt_d = '0;
            end else if (ref_cnt_q != RW'(REF_MAX_CYC)) begin
                ref_cnt_d = ref_cnt_q + 1'b1;
                if (ref_cnt_q == RW'(REF_MAX_CYC - 1)) viol[3] = 1'b1;
            end
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) ref_cnt_q <= '0;
        else               ref_cnt_q <= ref_cnt_d;
    end
`else
    assign viol[3] = 1'b0;
`endif

    always_comb begin
        if (clr_i) begin
            err_d     = viol;
            err_cnt_d = {15'd0, |viol};
        end else begin
            err_d     = err_q | viol;
            err_cnt_d = err_cnt_q;
            if ((|viol) && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            cmd_q       <= CMD_DESEL;
            done_q      <= 1'b0;
            done_prev_q <= 1'b0;
            state_q     <= ST_INIT_WAIT;
            init_cnt_q  <= '0;
            ar_cnt_q    <= '0;
            trp_cnt_q   <= '0;
            trfc_cnt_q  <= '0;
            init_ok_q   <= 1'b0;
            err_q       <= '0;
            err_cnt_q   <= '0;
        end else begin
            cmd_q       <= cmd_d;
            done_q      <= sdr_init_done;
            done_prev_q <= done_q;
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ar_cnt_q    <= ar_cnt_d;
            trp_cnt_q   <= trp_cnt_d;
            trfc_cnt_q  <= trfc_cnt_d;
            init_ok_q   <= init_ok_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_o     = cmd_q;
    assign init_ok_o = init_ok_q;
    assign err_o     = err_q;
    assign err_cnt_o = err_cnt_q;
endmodule

// File: tb/tb_sdram_cmd_checker.sv
// Bench for sdram_cmd_checker: directed init/spacing/refresh/clear/reset scenarios plus random
// command streams, all compared each cycle against a timestamp-based reference model.
module tb_sdram_cmd_checker;
    localparam int INIT_NOP_CYC = 10000;
    localparam int INIT_AR_CNT  = 2;
    localparam int TRP_CYC      = 3;
    localparam int TRFC_CYC     = 7;
    localparam int REF_MAX_CYC  = 1560;
`ifdef SDR_CMD_CHK_REF_EN
    localparam int REF_EN = 1;
`else
    localparam int REF_EN = 0;
`endif

    localparam int C_NOP = 1, C_ACT = 2, C_PRE = 6, C_AREF = 7, C_MRS = 8;

    logic        sdram_clk = 1'b0;
    logic        sdram_resetn = 1'b0;
    logic        sdr_cs_n = 1'b1, sdr_ras_n = 1'b1, sdr_cas_n = 1'b1, sdr_we_n = 1'b1;
    logic        sdr_init_done = 1'b0;
    logic        clr_i = 1'b0;
    logic [3:0]  cmd_o;
    logic        init_ok_o;
    logic [4:0]  err_o;
    logic [15:0] err_cnt_o;

    sdram_cmd_checker #(
        .INIT_NOP_CYC(INIT_NOP_CYC), .INIT_AR_CNT(INIT_AR_CNT), .TRP_CYC(TRP_CYC),
        .TRFC_CYC(TRFC_CYC), .REF_MAX_CYC(REF_MAX_CYC)
    ) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
        .sdr_cs_n(sdr_cs_n), .sdr_ras_n(sdr_ras_n), .sdr_cas_n(sdr_cas_n), .sdr_we_n(sdr_we_n),
        .sdr_init_done(sdr_init_done), .clr_i(clr_i),
        .cmd_o(cmd_o), .init_ok_o(init_ok_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    // Reference model: phases of the power-up sequence, timestamps of the last PRE/AREF,
    // and the refresh anchor; m_cmd/m_done hold what the DUT sampled at the previous edge.
    int         m_t, m_phase, m_nops, m_arefs, m_last_pre, m_last_aref, m_ref_anchor;
    int         m_cmd;
    logic       m_done, m_done_prev;
    logic [4:0] exp_err;
    int         exp_cnt;
    logic       exp_ok;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] enc(input int c);
        logic [3:0] p;
        case (c)
            0:       p = {1'b1, 3'($urandom_range(0, 7))};
            1:       p = 4'b0111;
            2:       p = 4'b0011;
            3:       p = 4'b0101;
            4:       p = 4'b0100;
            5:       p = 4'b0110;
            6:       p = 4'b0010;
            7:       p = 4'b0001;
            default: p = 4'b0000;
        endcase
        return p;
    endfunction

    function automatic int rand_cmd();
        if ($urandom_range(0, 99) < 80) return int'($urandom_range(0, 1));
        return int'($urandom_range(2, 8));
    endfunction

    task automatic model_reset();
        m_t = 0; m_phase = 0; m_nops = 0; m_arefs = 0;
        m_last_pre = -100000; m_last_aref = -100000; m_ref_anchor = 0;
        m_cmd = 0; m_done = 1'b0; m_done_prev = 1'b0;
        exp_err = '0; exp_cnt = 0; exp_ok = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_edge(input int new_cmd, input logic new_done, input logic clr);
        logic [4:0] v;
        int  ph;
        bit  idle;
        v = '0;
        ph = m_phase;
        idle = (m_cmd <= 1);
        m_t++;
        case (ph)
            0: if (idle) begin
                   m_nops++;
                   if (m_nops == INIT_NOP_CYC) m_phase = 1;
               end else v[0] = 1'b1;
            1: if (m_cmd == C_PRE) m_phase = 2; else if (!idle) v[0] = 1'b1;
            2: if (m_cmd == C_AREF) begin
                   m_arefs++;
                   if (m_arefs == INIT_AR_CNT) m_phase = 3;
               end else if (!idle) v[0] = 1'b1;
            3: if (m_cmd == C_MRS) begin
                   m_phase = 4; exp_ok = 1'b1; m_ref_anchor = m_t;
               end else if (!idle) v[0] = 1'b1;
            default: ;
        endcase
        if (!idle && (m_t - m_last_pre) < TRP_CYC) v[1] = 1'b1;
        if (!idle && (m_t - m_last_aref) < TRFC_CYC) v[2] = 1'b1;
        if (m_cmd == C_PRE) m_last_pre = m_t;
        if (m_cmd == C_AREF) m_last_aref = m_t;
        if (REF_EN != 0 && ph == 4) begin
            if (m_cmd != C_AREF && (m_t - m_ref_anchor) == REF_MAX_CYC) v[3] = 1'b1;
            if (m_cmd == C_AREF) m_ref_anchor = m_t;
        end
        v[4] = (m_done && ph != 4) || (ph == 4 && !m_done && m_done_prev);
        if (clr) begin
            exp_err = v;
            exp_cnt = (v != 0) ? 1 : 0;
        end else begin
            exp_err = exp_err | v;
            if (v != 0 && exp_cnt < 65535) exp_cnt++;
        end
        m_done_prev = m_done;
        m_done = new_done;
        m_cmd = new_cmd;
        exp_q.push_back(4'(new_cmd));
    endtask

    task automatic check_outputs();
        logic [3:0] e;
        e = exp_q.pop_front();
        check_eq("cmd_o", 32'(cmd_o), 32'(e));
        check_eq("err_o", 32'(err_o), 32'(exp_err));
        check_eq("err_cnt_o", 32'(err_cnt_o), exp_cnt);
        check_eq("init_ok_o", 32'(init_ok_o), 32'(exp_ok));
    endtask

    // Called right after a falling edge: drive, let the DUT sample, update model, compare.
    task automatic drive_cycle(input int c, input logic done, input logic clr);
        {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = enc(c);
        sdr_init_done = done;
        clr_i = clr;
        @(posedge sdram_clk);
        model_edge(c, done, clr);
        @(negedge sdram_clk);
        check_outputs();
    endtask

    task automatic idle_cycles(input int n, input logic done);
        for (int i = 0; i < n; i++) drive_cycle(C_NOP, done, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_cmd"}, 32'(cmd_o), 0);
        check_eq({tag, "_err"}, 32'(err_o), 0);
        check_eq({tag, "_cnt"}, 32'(err_cnt_o), 0);
        check_eq({tag, "_ok"}, 32'(init_ok_o), 0);
    endtask

    initial begin
        logic done_r;
        model_reset();
        repeat (3) @(negedge sdram_clk);
        check_all_zero("reset");
        sdram_resetn = 1'b1;

        // Legal power-up sequence
        idle_cycles(INIT_NOP_CYC + 2, 1'b0);
        drive_cycle(C_PRE, 1'b0, 1'b0);
        idle_cycles(3, 1'b0);
        drive_cycle(C_AREF, 1'b0, 1'b0);
        idle_cycles(7, 1'b0);
        drive_cycle(C_AREF, 1'b0, 1'b0);
        idle_cycles(7, 1'b0);
        drive_cycle(C_MRS, 1'b0, 1'b0);
        drive_cycle(C_NOP, 1'b1, 1'b0);
        check_eq("legal_init_ok", 32'(init_ok_o), 1);
        check_eq("legal_init_err", 32'(err_o), 0);
        check_eq("legal_init_cnt", 32'(err_cnt_o), 0);

        // tRFC then tRP violations in RUN
        drive_cycle(C_AREF, 1'b1, 1'b0);
        idle_cycles(3, 1'b1);
        drive_cycle(C_AREF, 1'b1, 1'b0);
        idle_cycles(7, 1'b1);
        drive_cycle(C_PRE, 1'b1, 1'b0);
        drive_cycle(C_PRE, 1'b1, 1'b0);
        idle_cycles(2, 1'b1);
        check_eq("spacing_err", 32'(err_o), 32'(5'b00110));
        check_eq("spacing_cnt", 32'(err_cnt_o), 2);

        // Refresh starvation
        idle_cycles(1500, 1'b1);
        check_eq("ref_early", 32'(err_o[3]), 0);
        idle_cycles(100, 1'b1);
        check_eq("ref_late", 32'(err_o[3]), REF_EN);
        check_eq("ref_cnt", 32'(err_cnt_o), 2 + REF_EN);
        idle_cycles(200, 1'b1);
        check_eq("ref_once", 32'(err_cnt_o), 2 + REF_EN);

        // Clear coinciding with a tRP violation
        drive_cycle(C_AREF, 1'b1, 1'b0);
        idle_cycles(7, 1'b1);
        drive_cycle(C_PRE, 1'b1, 1'b0);
        drive_cycle(C_PRE, 1'b1, 1'b0);
        drive_cycle(C_NOP, 1'b1, 1'b1);
        check_eq("clr_err", 32'(err_o), 32'(5'b00010));
        check_eq("clr_cnt", 32'(err_cnt_o), 1);

        // Random traffic in RUN
        done_r = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) done_r = ~done_r;
            drive_cycle(rand_cmd(), done_r, $urandom_range(0, 49) == 0);
        end
        drive_cycle(C_PRE, done_r, 1'b0);
        drive_cycle(C_PRE, done_r, 1'b0);
        drive_cycle(C_NOP, done_r, 1'b0);
        check_eq("pre_reset_err1", 32'(err_o[1]), 1);

        // Asynchronous reset in the middle of a cycle
        @(posedge sdram_clk);
        #2 sdram_resetn = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge sdram_clk);
        model_reset();
        sdr_init_done = 1'b0;
        sdram_resetn = 1'b1;

        // Early ACT; FSM must still be waiting, so a later PRE is also an init error
        idle_cycles(499, 1'b0);
        drive_cycle(C_ACT, 1'b0, 1'b0);
        drive_cycle(C_NOP, 1'b0, 1'b0);
        check_eq("early_act_err", 32'(err_o), 32'(5'b00001));
        check_eq("early_act_cnt", 32'(err_cnt_o), 1);
        idle_cycles(3, 1'b0);
        drive_cycle(C_PRE, 1'b0, 1'b0);
        drive_cycle(C_NOP, 1'b0, 1'b0);
        check_eq("still_wait_cnt", 32'(err_cnt_o), 2);

        // Random traffic during init
        for (int i = 0; i < 300; i++)
            drive_cycle(rand_cmd(), $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sdram_cmd_checker.md
# sdram_cmd_checker

Synthesizable checker on the SDRAM command bus of the `sdr_ctrl` core, downstream of the controller's command outputs (`sdr_cs_n`/`sdr_ras_n`/`sdr_cas_n`/`sdr_we_n`, `sdr_init_done`). It decodes every command, tracks the power-up initialisation sequence with an FSM, enforces tRP and tRFC spacing and the refresh interval, and reports sticky error flags plus a saturating violation counter. It gives silicon and FPGA builds the same protocol coverage that simulation gets from the assertions.

## Interface
Parameters:
- `INIT_NOP_CYC`, 10000: minimum NOP/DESEL cycles after reset before the first command.
- `INIT_AR_CNT`, 2: number of AUTO REFRESH commands required during init.
- `TRP_CYC`, 3: a PRE forbids any non-NOP/DESEL command for cycles 1..TRP_CYC-1 after it.
- `TRFC_CYC`, 7: an AREF forbids any non-NOP/DESEL command for cycles 1..TRFC_CYC-1 after it.
- `REF_MAX_CYC`, 1560: maximum cycles between consecutive AREFs in RUN.

Ports:
- `sdram_clk`, in, 1: single clock.
- `sdram_resetn`, in, 1: asynchronous, active-low reset.
- `sdr_cs_n`, `sdr_ras_n`, `sdr_cas_n`, `sdr_we_n`, in, 1 each: monitored command pins.
- `sdr_init_done`, in, 1: controller's init-complete indication.
- `clr_i`, in, 1: synchronous clear of `err_o` and `err_cnt_o`.
- `cmd_o`, out, 4: decoded command. DESEL=0, NOP=1, ACT=2, RD=3, WR=4, BST=5, PRE=6, AREF=7, MRS=8.
- `init_ok_o`, out, 1: the init sequence completed legally.
- `err_o`, out, 5: sticky flags. [0] INIT_SEQ, [1] TRP, [2] TRFC, [3] REF, [4] DONE.
- `err_cnt_o`, out, 16: saturating count of violation cycles.

## Operation
- Decode from {cs_n,ras_n,cas_n,we_n}: cs_n=1 gives DESEL; 0111 NOP, 0011 ACT, 0101 RD, 0100 WR, 0110 BST, 0010 PRE, 0001 AREF, 0000 MRS.
- FSM states:
  - INIT_WAIT: count NOP/DESEL cycles. Any other command before `INIT_NOP_CYC` sets err[0] and the FSM stays. At count, go to INIT_PRE.
  - INIT_PRE: PRE goes to INIT_AR. Any other non-NOP/DESEL command sets err[0].
  - INIT_AR: count AREFs. After `INIT_AR_CNT`, go to INIT_MRS. Any other non-NOP/DESEL command sets err[0].
  - INIT_MRS: MRS goes to RUN and sets `init_ok_o`. Any other non-NOP/DESEL command sets err[0].
  - RUN: terminal until reset.
- err[1]/err[2]: spacing windows are checked in every state. A new PRE/AREF restarts its own window.
- err[3]: in RUN, an interval counter resets on each AREF. If the counter reaches `REF_MAX_CYC` without an AREF, err[3] sets once, and the counter holds until the next AREF.
- err[4]: set if `sdr_init_done` is high while the FSM is not in RUN, or if it falls while in RUN.
- `err_cnt_o` increments by 1 per cycle in which at least one check fires, and saturates at 16'hFFFF.
- `clr_i` clears `err_o` and `err_cnt_o`. If a violation fires in the same cycle, the new bits are set and the count becomes 1. `clr_i` does not affect the FSM or `init_ok_o`.

## Timing
- Inputs are registered once. `cmd_o` reflects pins sampled at edge N and is valid after edge N.
- `err_o`, `err_cnt_o` and `init_ok_o` update at edge N+1 for a command sampled at edge N.
- Reset values:
  - `cmd_o`=0 (DESEL), `init_ok_o`=0, `err_o`=0, `err_cnt_o`=0.
  - FSM in INIT_WAIT, all counters 0, no spacing window open.
- Reset asserted mid-operation: immediate return to reset values. Error history is lost.
- Counter widths: $clog2 of the respective parameter plus 1. The init counter saturates at `INIT_NOP_CYC`.

## Configuration
- `SDR_CMD_CHK_REF_EN` defined: the refresh-interval counter and err[3] are implemented.
- Not defined: no refresh counter is instantiated, err[3] is tied to 0, and it never contributes to `err_cnt_o`.

## Test plan
- Legal init: 10000 NOPs, PRE, 2 AREFs 8 cycles apart, MRS, then `sdr_init_done`=1. Expect `init_ok_o`=1 one cycle after MRS, `err_o`=0, `err_cnt_o`=0.
- ACT at cycle 500 after reset. Expect err[0]=1 one cycle later, `err_cnt_o`=1, FSM still in INIT_WAIT.
- AREF, then AREF 4 cycles later. Expect err[2]=1. PRE followed by PRE 1 cycle later: expect err[1]=1 and `err_cnt_o`=2.
- In RUN, no AREF for 1560 cycles. Expect err[3]=1 exactly once and `err_cnt_o`+1. With `SDR_CMD_CHK_REF_EN` undefined, err[3] stays 0.
- `clr_i`=1 in the same cycle as a TRP violation. Expect `err_o`=5'b00010 and `err_cnt_o`=1.
- `sdram_resetn` pulsed low in RUN with errors set. Expect all outputs 0 immediately and the init checks restarted.
